cover_hit_serializer: RTL and testbench

COVER_HIT_SERIALIZER -- requirements
Module: cover_hit_serializer

---
 rtl/cover_pkg.sv | 14 +
 rtl/cover_lsb_pick.sv | 27 ++
 rtl/cover_hit_serializer.sv | 111 +++++++++++
 tb/tb_cover_hit_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared coverage types: global point count, 64-bit cover index and the serializer FSM states.
package cover_pkg;

  localparam int COVER_TOTAL = 28338;

  typedef logic [63:0] cover_idx_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } cover_state_e;

endpackage

// File: rtl/cover_lsb_pick.sv
// Lowest-set-bit finder: one-hot mask, binary position and any flag; purely combinational.
module cover_lsb_pick #(
  parameter int WIDTH = 37,
  parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic [PW-1:0]    pos_o,
  output logic             any_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Two's-complement trick isolates the lowest set bit; with WIDTH=1 it reduces to vec_i.
  assign onehot_o = vec_i & (~vec_i + ONE);
  assign any_o    = |vec_i;

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_o[i]) begin
        pos_o = pos_o | PW'(i);
      end
    end
  end

endmodule

// File: rtl/cover_hit_serializer.sv
// Records first toggle hits per bit and serializes their global indices, lowest bit first.
// Latency 2 from hit to out_valid; out_valid/out_index hold while out_ready is low.
module cover_hit_serializer #(
  parameter int WIDTH       = 37,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
  parameter int CW          = $clog2(WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [WIDTH-1:0]      valid,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output cover_pkg::cover_idx_t out_index,
  output logic [CW-1:0]         hit_count,
  output logic                  busy
);

  import cover_pkg::*;

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
    $error("cover_hit_serializer: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  cover_state_e     state_q, state_d;
  logic [WIDTH-1:0] seen_q, seen_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  cover_idx_t       out_index_q, out_index_d;
  logic [CW-1:0]    hit_count_q, hit_count_d;

  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] pick_onehot;
  logic [PW-1:0]    pick_pos;
  logic             pick_any;
  logic             load;

  cover_lsb_pick #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_pick (
    .vec_i    (pend_q),
    .onehot_o (pick_onehot),
    .pos_o    (pick_pos),
    .any_o    (pick_any)
  );

  assign new_hits = (state_q == RUN && en) ? (valid & ~seen_q) : '0;
  // The output slot refills whenever it is empty or being consumed this cycle.
  assign load     = ~out_valid_q | out_ready;

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q | new_hits;
    pend_d      = pend_q | new_hits;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    hit_count_d = hit_count_q + CW'($countones(new_hits));

    if (load) begin
      out_valid_d = pick_any;
      pend_d      = (pend_q & ~pick_onehot) | new_hits;
      if (pick_any) begin
        out_index_d = cover_idx_t'(COVER_INDEX) + cover_idx_t'(pick_pos);
      end
    end

    case (state_q)
      RUN: begin
        if (clr) state_d = DRAIN;
      end
      DRAIN: begin
        if (pend_q == '0 && !out_valid_q) state_d = CLEAR;
      end
      CLEAR: begin
        seen_d      = '0;
        hit_count_d = '0;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      seen_q      <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_count = hit_count_q;
  assign busy      = (state_q != RUN);

endmodule

// File: tb/tb_cover_hit_serializer.sv
// Directed bench: stimulus pushes expected indices, a negedge monitor pops and compares emissions.
module tb_cover_hit_serializer;

  localparam int WIDTH = 37;
  localparam int CIDX  = 100;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b1;
  logic [WIDTH-1:0]  valid = '0;
  logic              clr = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [63:0]       out_index;
  logic [5:0]        hit_count;
  logic              busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int emit_cnt = 0;
  int last_emit_cyc = 0;
  logic [63:0] expq[$];

  cover_hit_serializer #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (CIDX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .valid     (valid),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .hit_count (hit_count),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clock) begin
    logic [63:0] e;
    if (reset && out_valid && out_ready) begin
      emit_cnt++;
      last_emit_cyc = cyc;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_emit: got %0d want none", out_index);
      end else begin
        e = expq.pop_front();
        chk("emit_index", out_index, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_not_busy(input string name);
    for (int i = 0; i < 100 && busy; i++) @(negedge clock);
    chk(name, busy, 0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b1;
    wait_not_busy("clear_done");
    tick();
    chk("clear_hit_count", hit_count, 0);
  endtask

  initial begin
    int e0;
    int pulses;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // Single hit: latency 2, index CIDX+0
    out_ready = 1'b1;
    valid = 37'h1;
    expq.push_back(64'(CIDX));
    tick();
    valid = '0;
    @(negedge clock);
    chk("lat_edge_n", out_valid, 0);
    chk("lat_hit_count", hit_count, 1);
    @(negedge clock);
    chk("lat_edge_n1", out_valid, 1);
    repeat (3) tick();
    chk("t1_drained", expq.size(), 0);
    do_clear();

    // Three bits in one cycle, emitted lowest first on consecutive cycles
    valid = 37'h10_0000_0009;
    expq.push_back(64'(CIDX + 0));
    expq.push_back(64'(CIDX + 3));
    expq.push_back(64'(CIDX + 36));
    tick();
    valid = '0;
    @(negedge clock);
    chk("burst_pre", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("burst_consec", out_valid, 1);
    end
    @(negedge clock);
    chk("burst_post", out_valid, 0);
    chk("burst_hit_count", hit_count, 3);
    chk("t2_drained", expq.size(), 0);
    tick();
    do_clear();

    // Repeated hits on bit 5 and a stalled consumer
    out_ready = 1'b0;
    e0 = emit_cnt;
    valid = 37'h20;
    expq.push_back(64'(CIDX + 5));
    tick();
    valid = '0;
    pulses = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        valid = 37'h20;
        pulses++;
      end else begin
        valid = '0;
      end
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_index", out_index, 64'(CIDX + 5));
      tick();
    end
    valid = '0;
    out_ready = 1'b1;
    while (pulses < 10) begin
      valid = 37'h20;
      tick();
      valid = '0;
      tick();
      pulses++;
    end
    repeat (3) tick();
    chk("repeat_one_emit", emit_cnt - e0, 1);
    chk("repeat_hit_count", hit_count, 1);
    do_clear();

    // Clear with pending hits, capture on the clr edge, no capture while draining
    out_ready = 1'b0;
    valid = 37'h22;
    tick();
    valid = 37'h200;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    valid = 37'h10_0000;
    expq.push_back(64'(CIDX + 1));
    expq.push_back(64'(CIDX + 5));
    expq.push_back(64'(CIDX + 9));
    @(negedge clock);
    chk("drain_busy", busy, 1);
    chk("drain_hit_count", hit_count, 3);
    tick();
    valid = '0;
    out_ready = 1'b1;
    wait_not_busy("drain_done");
    chk("clear_one_cycle", cyc - last_emit_cyc, 3);
    chk("drain_hit_count_zero", hit_count, 0);
    chk("drain_all_emitted", expq.size(), 0);
    tick();
    valid = 37'h20;
    expq.push_back(64'(CIDX + 5));
    tick();
    valid = '0;
    repeat (4) tick();
    chk("rehit_hit_count", hit_count, 1);
    chk("rehit_emitted", expq.size(), 0);
    do_clear();

    // Reset while emitting with hits still pending
    out_ready = 1'b0;
    valid = 37'h54;
    tick();
    valid = '0;
    tick();
    @(negedge clock);
    chk("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_index", out_index, 0);
    chk("async_rst_hit_count", hit_count, 0);
    chk("async_rst_busy", busy, 0);
    e0 = emit_cnt;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    repeat (10) tick();
    chk("no_stale_emit", emit_cnt - e0, 0);
    chk("post_reset_hit_count", hit_count, 0);

    // Capture disabled
    e0 = emit_cnt;
    en = 1'b0;
    valid = '1;
    repeat (5) tick();
    valid = '0;
    en = 1'b1;
    repeat (4) tick();
    chk("en0_hit_count", hit_count, 0);
    chk("en0_no_emit", emit_cnt - e0, 0);
    chk("final_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
